sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator.sv | 130 +++++++++++++
 tb/tb_sequence_generator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator.sv
// Serialises a captured PAT_W-bit pattern MSB first, repeated repeat_cnt+1 times with gap_cnt idle cycles between repetitions.
// Latency: first bit one cycle after the accepting edge; done pulses one cycle after the last bit; all outputs registered.
// Backpressure: none downstream; start is only taken while ready=1, requests while busy are dropped, not queued.
module sequence_generator #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [3:0]       repeat_cnt,
    input  logic [3:0]       gap_cnt,
    output logic             ready,
    output logic             busy,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             done
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(PAT_W - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND   = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]       state;
    logic [PAT_W-1:0] pat_reg;    // pattern captured at acceptance
    logic [BW-1:0]    bit_cnt;    // index of the bit currently on serial_out
    logic [3:0]       rep_left;   // repetitions still to start after the current one
    logic [3:0]       gap_reg;    // captured gap length
    logic [3:0]       gap_left;   // GAP cycles remaining after the current one

    // Single registered FSM: state, counters and every output advance together on each edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pat_reg    <= '0;
            bit_cnt    <= '0;
            rep_left   <= '0;
            gap_reg    <= '0;
            gap_left   <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            serial_out <= 1'b0;
            bit_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SEND;
                        pat_reg    <= pattern_in;
                        rep_left   <= repeat_cnt;
                        gap_reg    <= gap_cnt;
                        gap_left   <= '0;
                        bit_cnt    <= LAST_IDX;
                        serial_out <= pattern_in[PAT_W-1];
                        bit_valid  <= 1'b1;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                SEND: begin
                    if (bit_cnt != '0) begin
                        bit_cnt    <= bit_cnt - BIT_ONE;
                        serial_out <= pat_reg[bit_cnt - BIT_ONE];
                    end else if (rep_left != 4'd0) begin
                        if (gap_reg != 4'd0) begin
                            state      <= GAP;
                            gap_left   <= gap_reg - 4'd1;
                            serial_out <= 1'b0;
                            bit_valid  <= 1'b0;
                        end else begin
                            // Zero gap: next repetition's MSB follows the LSB directly.
                            rep_left   <= rep_left - 4'd1;
                            bit_cnt    <= LAST_IDX;
                            serial_out <= pat_reg[PAT_W-1];
                        end
                    end else begin
                        state      <= FINISH;
                        serial_out <= 1'b0;
                        bit_valid  <= 1'b0;
                        done       <= 1'b1;
                    end
                end

                GAP: begin
                    if (gap_left != 4'd0) begin
                        gap_left <= gap_left - 4'd1;
                    end else begin
                        state      <= SEND;
                        rep_left   <= rep_left - 4'd1;
                        bit_cnt    <= LAST_IDX;
                        serial_out <= pat_reg[PAT_W-1];
                        bit_valid  <= 1'b1;
                    end
                end

                FINISH: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    ready    <= 1'b1;
                    bit_cnt  <= '0;
                    rep_left <= '0;
                    gap_left <= '0;
                end

                default: begin
                    state      <= IDLE;
                    pat_reg    <= '0;
                    bit_cnt    <= '0;
                    rep_left   <= '0;
                    gap_reg    <= '0;
                    gap_left   <= '0;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                    serial_out <= 1'b0;
                    bit_valid  <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: directed frames plus random start/reset traffic.
// Expected bit/done events are queued per accepted frame with their cycle numbers.
// A monitor sampling just after each rising edge pops and compares them.
module tb_sequence_generator;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] pattern_in = '0;
    logic [3:0]   repeat_cnt = '0;
    logic [3:0]   gap_cnt = '0;
    logic         ready, busy, serial_out, bit_valid, done;

    sequence_generator #(.PAT_W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern_in (pattern_in),
        .repeat_cnt (repeat_cnt),
        .gap_cnt    (gap_cnt),
        .ready      (ready),
        .busy       (busy),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ready_from = 0;   // first cycle in which the model expects ready=1
    bit   chk_en = 1'b0;
    bit   end_req = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: lay out every event of a frame accepted at the end of cycle cyc.
    task automatic model_frame(input logic [W-1:0] p, input logic [3:0] r, input logic [3:0] g);
        int c;
        c = cyc + 1;
        for (int k = 0; k <= int'(r); k++) begin
            for (int i = W - 1; i >= 0; i--) begin
                q.push_back('{c, 1'b0, p[i]});
                c++;
            end
            if (k < int'(r)) c += int'(g);
        end
        q.push_back('{c, 1'b1, 1'b0});
        ready_from = c + 1;
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model.
    task automatic drive(input bit rst, input bit st, input logic [W-1:0] p,
                         input logic [3:0] r, input logic [3:0] g);
        @(negedge clk);
        reset      = rst;
        start      = st;
        pattern_in = p;
        repeat_cnt = r;
        gap_cnt    = g;
        if (rst) begin
            while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
            ready_from = cyc + 1;
        end else if (st && cyc >= ready_from) begin
            model_frame(p, r, g);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, W'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // Monitor: per-cycle handshake checks plus scoreboard pops on bit/done events.
    initial begin : monitor
        bit   exp_rdy;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (end_req) break;
            if (chk_en) begin
                exp_rdy = (cyc >= ready_from);
                checks++;
                if (ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, exp_rdy);
                end
                checks++;
                if (busy !== !exp_rdy) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, !exp_rdy);
                end
                if (bit_valid !== 1'b1) begin
                    checks++;
                    if (serial_out !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_serial cyc=%0d got=%b exp=0", cyc, serial_out);
                    end
                end
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_event cyc=%0d exp_cyc=%0d exp_done=%b exp_bit=%b",
                             cyc, e.cyc, e.is_done, e.val);
                end
                if (bit_valid === 1'b1 || done === 1'b1) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event cyc=%0d bit_valid=%b done=%b serial=%b",
                                 cyc, bit_valid, done, serial_out);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != cyc || done !== e.is_done || bit_valid !== !e.is_done ||
                            (!e.is_done && serial_out !== e.val)) begin
                            errors++;
                            $display("FAIL event cyc=%0d got(v=%b d=%b s=%b) exp(cyc=%0d d=%b s=%b)",
                                     cyc, bit_valid, done, serial_out, e.cyc, e.is_done, e.val);
                        end
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Stimulus
    initial begin : driver
        bit         rst, st;
        logic [3:0] r, g;
        int         guard;

        drive(1'b1, 1'b0, '0, '0, '0);
        chk_en = 1'b1;
        drive(1'b1, 1'b1, 4'b1111, 4'd0, 4'd0);
        drive(1'b1, 1'b0, '0, '0, '0);
        idle(2);

        // Single frame, then one repeat without a gap, then one repeat with a 2-cycle gap.
        drive(1'b0, 1'b1, 4'b1011, 4'd0, 4'd0);
        idle(7);
        drive(1'b0, 1'b1, 4'b1011, 4'd1, 4'd0);
        idle(11);
        drive(1'b0, 1'b1, 4'b1011, 4'd1, 4'd2);
        idle(13);

        // Start pulse and pattern change mid-frame must not disturb the frame.
        drive(1'b0, 1'b1, 4'b1011, 4'd0, 4'd0);
        drive(1'b0, 1'b0, 4'b1011, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 4'b0000, 4'd0, 4'd0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 4'b0000, 4'd0, 4'd0);

        // Reset in the middle of a long frame, then an immediate restart.
        drive(1'b0, 1'b1, 4'b1011, 4'd3, 4'd1);
        idle(2);
        drive(1'b1, 1'b0, 4'b1011, 4'd3, 4'd1);
        drive(1'b0, 1'b1, 4'b0110, 4'd0, 4'd0);
        idle(7);

        // Start held high: back-to-back frames.
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 4'b1101, 4'd0, 4'd0);
        idle(8);

        // Random traffic with mid-frame input changes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            g   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            drive(rst, st, W'($urandom), r, g);
        end

        guard = 0;
        while ((q.size() != 0 || cyc < ready_from) && guard < 400) begin
            drive(1'b0, 1'b0, '0, '0, '0);
            guard++;
        end
        idle(2);
        end_req = 1'b1;
    end

endmodule
